mac_lookup_ctrl: RTL and testbench

//  Requester side of the mac_mem MAC table: takes one parsed header (DA, SA, ingress port) per frame.

---
 rtl/mac_lookup_ctrl_if.sv | 50 +++++
 rtl/mac_lookup_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mac_lookup_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_lookup_ctrl_if.sv
// Channel bundle around the MAC lookup controller: parser header in, MAC-table
// request/response, and the per-frame forwarding decision out.
interface mac_lookup_ctrl_if #(
  parameter int pNUM_PORTS  = 4,
  parameter int pADDR_WIDTH = 14
);
  localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

  // header from the frame parser
  logic                   ifr_valid;
  logic [pADDR_WIDTH-1:0] ifr_da;
  logic [pADDR_WIDTH-1:0] ifr_sa;
  logic [PW-1:0]          ifr_port;
  logic                   ofr_ready;

  // learn/lookup request to the table and its response
  logic [pADDR_WIDTH-1:0] osa;
  logic [pADDR_WIDTH-1:0] oda;
  logic [PW-1:0]          opnum;
  logic                   owr_en;
  logic [PW-1:0]          itbl_pnum;
  logic                   itbl_ready;

  // forwarding decision to the queue manager
  logic                   odec_valid;
  logic [pNUM_PORTS-1:0]  odec_mask;
  logic                   odec_flood;
  logic                   odec_drop;
  logic                   idec_ready;

  // controller side
  modport master (
    input  ifr_valid, ifr_da, ifr_sa, ifr_port,
    output ofr_ready,
    output osa, oda, opnum, owr_en,
    input  itbl_pnum, itbl_ready,
    output odec_valid, odec_mask, odec_flood, odec_drop,
    input  idec_ready
  );

  // environment side: parser, table and queue manager
  modport slave (
    output ifr_valid, ifr_da, ifr_sa, ifr_port,
    input  ofr_ready,
    input  osa, oda, opnum, owr_en,
    output itbl_pnum, itbl_ready,
    input  odec_valid, odec_mask, odec_flood, odec_drop,
    output idec_ready
  );
endinterface

// File: rtl/mac_lookup_ctrl.sv
// Requester for the MAC table: one header in, one learn+lookup out, then a
// unicast / flood / drop egress mask per frame. One frame in flight at a time.
module mac_lookup_ctrl #(
  parameter int pNUM_PORTS      = 4,
  parameter int pADDR_WIDTH     = 14,
  parameter int pLOOKUP_TIMEOUT = 8
) (
  input  logic              iclk,
  input  logic              irst_n,
  mac_lookup_ctrl_if.master bus
);
  localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;
  localparam int CW = $clog2(pLOOKUP_TIMEOUT);
  localparam logic [CW-1:0]          CNT_LAST      = CW'(pLOOKUP_TIMEOUT - 1);
  localparam logic [pADDR_WIDTH-1:0] ADDR_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] sa_q, sa_d;
  logic [pADDR_WIDTH-1:0] da_q, da_d;
  logic [PW-1:0]          pnum_q, pnum_d;
  logic                   wr_en_q, wr_en_d;
  logic                   fr_ready_q, fr_ready_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dec_valid_q, dec_valid_d;
  logic [pNUM_PORTS-1:0]  mask_q, mask_d;
  logic                   flood_q, flood_d;
  logic                   drop_q, drop_d;

  // Per-port decode: flood mask excludes the ingress port; one-hot of the
  // table's answer. A table port outside 0..pNUM_PORTS-1 decodes to all zeros.
  logic [pNUM_PORTS-1:0]  flood_mask;
  logic [pNUM_PORTS-1:0]  tbl_onehot;
  logic                   tbl_in_range;

  for (genvar gi = 0; gi < pNUM_PORTS; gi++) begin : g_port
    assign flood_mask[gi] = (pnum_q != PW'(gi));
    assign tbl_onehot[gi] = (bus.itbl_pnum == PW'(gi));
  end

  assign tbl_in_range = |tbl_onehot;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    da_d    = da_q;
    pnum_d  = pnum_q;
    wr_en_d = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    flood_d = flood_q;
    drop_d  = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ifr_valid && fr_ready_q) begin
          sa_d    = bus.ifr_sa;
          da_d    = bus.ifr_da;
          pnum_d  = bus.ifr_port;
          // an all-ones source is not a real station, so nothing is learned
          wr_en_d = (bus.ifr_sa != ADDR_ALL_ONES);
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (da_q == ADDR_ALL_ONES) begin
          state_d = ST_OUT;
          mask_d  = flood_mask;
          flood_d = 1'b1;
          drop_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end

      ST_WAIT: begin
        if (bus.itbl_ready) begin
          state_d = ST_OUT;
          if (!tbl_in_range) begin
            mask_d  = flood_mask;
            flood_d = 1'b1;
            drop_d  = 1'b0;
          end else if (bus.itbl_pnum == pnum_q) begin
            mask_d  = '0;
            flood_d = 1'b0;
            drop_d  = 1'b1;
          end else begin
            mask_d  = tbl_onehot;
            flood_d = 1'b0;
            drop_d  = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_OUT;
          mask_d  = flood_mask;
          flood_d = 1'b1;
          drop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (bus.idec_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // look-ahead so both handshake outputs are registered yet cycle-accurate
    dec_valid_d = (state_d == ST_OUT);
    fr_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      sa_q        <= '0;
      da_q        <= '0;
      pnum_q      <= '0;
      wr_en_q     <= 1'b0;
      fr_ready_q  <= 1'b0;
      cnt_q       <= '0;
      dec_valid_q <= 1'b0;
      mask_q      <= '0;
      flood_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      da_q        <= da_d;
      pnum_q      <= pnum_d;
      wr_en_q     <= wr_en_d;
      fr_ready_q  <= fr_ready_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      mask_q      <= mask_d;
      flood_q     <= flood_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.ofr_ready  = fr_ready_q;
  assign bus.osa        = sa_q;
  assign bus.oda        = da_q;
  assign bus.opnum      = pnum_q;
  assign bus.owr_en     = wr_en_q;
  assign bus.odec_valid = dec_valid_q;
  assign bus.odec_mask  = mask_q;
  assign bus.odec_flood = flood_q;
  assign bus.odec_drop  = drop_q;
endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Scoreboarded bench for mac_lookup_ctrl: the bench plays parser, MAC table and
// queue manager; a negedge monitor pops expected decisions on each handshake.
`timescale 1ns/1ps
module tb_mac_lookup_ctrl;
  localparam int N  = 4;
  localparam int AW = 14;
  localparam int T  = 8;
  localparam int PW = 2;
  localparam logic [AW-1:0] ONES = '1;

  typedef struct {
    logic [N-1:0] mask;
    logic         flood;
    logic         drop;
  } dec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_lookup_ctrl_if #(.pNUM_PORTS(N), .pADDR_WIDTH(AW)) bus ();

  mac_lookup_ctrl #(
    .pNUM_PORTS     (N),
    .pADDR_WIDTH    (AW),
    .pLOOKUP_TIMEOUT(T)
  ) dut (
    .iclk  (clk),
    .irst_n(rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  dec_t sb[$];
  logic [PW-1:0] tbl [logic [AW-1:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decision rules straight from the forwarding definition.
  function automatic dec_t ref_dec(input logic [AW-1:0] da, input int port,
                                   input bit hit, input int pnum);
    dec_t d;
    if (da == ONES || !hit || pnum >= N) begin
      d.mask  = N'(((1 << N) - 1) & ~(1 << port));
      d.flood = 1'b1;
      d.drop  = 1'b0;
    end else if (pnum == port) begin
      d.mask  = '0;
      d.flood = 1'b0;
      d.drop  = 1'b1;
    end else begin
      d.mask  = N'(1 << pnum);
      d.flood = 1'b0;
      d.drop  = 1'b0;
    end
    return d;
  endfunction

  always @(negedge clk) begin
    dec_t e;
    if (rst_n && bus.odec_valid && bus.idec_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_decision", 1, 0);
      end else begin
        e = sb.pop_front();
        check("dec_mask",  32'(bus.odec_mask),  32'(e.mask));
        check("dec_flood", 32'(bus.odec_flood), 32'(e.flood));
        check("dec_drop",  32'(bus.odec_drop),  32'(e.drop));
        $display("decision mask=%b flood=%0d drop=%0d", bus.odec_mask, bus.odec_flood, bus.odec_drop);
      end
    end
  end

  // All tasks are entered and left just after a rising edge.
  task automatic accept_header(input logic [AW-1:0] da, input logic [AW-1:0] sa,
                               input logic [PW-1:0] port, output bit ok);
    int guard = 0;
    while (bus.ofr_ready !== 1'b1 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = (bus.ofr_ready === 1'b1);
    if (!ok) begin
      check("ofr_ready_timeout", 32'(bus.ofr_ready), 1);
      return;
    end
    bus.ifr_valid = 1'b1;
    bus.ifr_da    = da;
    bus.ifr_sa    = sa;
    bus.ifr_port  = port;
    @(posedge clk); #1;
    bus.ifr_valid = 1'b0;
    bus.ifr_da    = AW'($urandom);
    bus.ifr_sa    = AW'($urandom);
    bus.ifr_port  = PW'($urandom);
  endtask

  task automatic run_frame(input logic [AW-1:0] da, input logic [AW-1:0] sa,
                           input logic [PW-1:0] port, input bit hit, input int pnum,
                           input int delay, input int hold);
    bit ok;
    int lat;
    lat = (da == ONES) ? 2 : (hit ? 3 + delay : 2 + T);
    sb.push_back(ref_dec(da, int'(port), hit, pnum));
    accept_header(da, sa, port, ok);
    if (!ok) begin
      void'(sb.pop_back());
      return;
    end
    check("req_owr_en", 32'(bus.owr_en), (sa != ONES) ? 1 : 0);
    check("req_osa",    32'(bus.osa),    32'(sa));
    check("req_oda",    32'(bus.oda),    32'(da));
    check("req_opnum",  32'(bus.opnum),  32'(port));
    check("req_ofr_ready", 32'(bus.ofr_ready), 0);
    // stray table answer during REQ must be ignored
    bus.itbl_ready = 1'($urandom_range(0, 1));
    bus.itbl_pnum  = PW'($urandom);
    for (int cyc = 2; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      check("odec_valid_timing", 32'(bus.odec_valid), (cyc == lat) ? 1 : 0);
      if (cyc < lat) begin
        bus.itbl_ready = hit && (cyc == 2 + delay);
        bus.itbl_pnum  = (hit && cyc == 2 + delay) ? PW'(pnum) : PW'($urandom);
      end
    end
    bus.idec_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.ifr_valid  = 1'($urandom_range(0, 1));
      bus.ifr_da     = AW'($urandom);
      bus.ifr_sa     = AW'($urandom);
      bus.itbl_ready = 1'($urandom_range(0, 1));
      bus.itbl_pnum  = PW'($urandom);
      @(posedge clk); #1;
      check("hold_odec_valid", 32'(bus.odec_valid), 1);
      check("hold_ofr_ready",  32'(bus.ofr_ready),  0);
      check("hold_owr_en",     32'(bus.owr_en),     0);
    end
    bus.ifr_valid  = 1'b0;
    bus.itbl_ready = 1'b0;
    bus.idec_ready = 1'b1;
    @(posedge clk); #1;
    check("release_odec_valid", 32'(bus.odec_valid), 0);
    check("release_ofr_ready",  32'(bus.ofr_ready),  1);
    bus.idec_ready = 1'b0;
    $display("frame da=%h sa=%h port=%0d hit=%0d pnum=%0d delay=%0d hold=%0d", da, sa, port, hit, pnum, delay, hold);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ofr_ready"},  32'(bus.ofr_ready),  0);
    check({tag, "_owr_en"},     32'(bus.owr_en),     0);
    check({tag, "_osa"},        32'(bus.osa),        0);
    check({tag, "_oda"},        32'(bus.oda),        0);
    check({tag, "_opnum"},      32'(bus.opnum),      0);
    check({tag, "_odec_valid"}, 32'(bus.odec_valid), 0);
    check({tag, "_odec_mask"},  32'(bus.odec_mask),  0);
    check({tag, "_odec_flood"}, 32'(bus.odec_flood), 0);
    check({tag, "_odec_drop"},  32'(bus.odec_drop),  0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    check("post_release_ofr_ready", 32'(bus.ofr_ready), 0);
    @(posedge clk); #1;
    check("first_cycle_ofr_ready", 32'(bus.ofr_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [AW-1:0] da, sa;
    logic [PW-1:0] port;
    bit hit;
    int pnum;

    bus.ifr_valid  = 1'b0;
    bus.ifr_da     = '0;
    bus.ifr_sa     = '0;
    bus.ifr_port   = '0;
    bus.itbl_pnum  = '0;
    bus.itbl_ready = 1'b0;
    bus.idec_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset();

    // stray table answers while idle
    for (int i = 0; i < 4; i++) begin
      bus.itbl_ready = 1'b1;
      bus.itbl_pnum  = PW'(i);
      @(posedge clk); #1;
      check("idle_stray_odec_valid", 32'(bus.odec_valid), 0);
      check("idle_stray_ofr_ready",  32'(bus.ofr_ready),  1);
    end
    bus.itbl_ready = 1'b0;

    run_frame(14'h0456, 14'h0123, 2'd1, 1, 2, 0, 0);      // hit -> 0100
    run_frame(14'h0777, 14'h0555, 2'd3, 0, 0, 0, 0);      // miss -> 0111 at cycle 10
    run_frame(14'h3FFF, 14'h0011, 2'd0, 0, 0, 0, 0);      // broadcast -> 1110
    run_frame(14'h3FFF, 14'h3FFF, 2'd2, 0, 0, 0, 0);      // broadcast, no learn
    run_frame(14'h0222, 14'h3FFF, 2'd1, 1, 3, 1, 1);      // invalid SA, still looked up
    run_frame(14'h0aaa, 14'h0bbb, 2'd2, 1, 2, 3, 2);      // filtered
    run_frame(14'h0abc, 14'h0def, 2'd0, 1, 3, T - 1, 0);  // hit on last WAIT cycle
    run_frame(14'h0100, 14'h0200, 2'd1, 1, 0, 2, 20);     // long backpressure

    // reset in mid-WAIT discards the frame
    accept_header(14'h0300, 14'h0301, 2'd3, ok);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_all_zero("wait_reset");
    @(posedge clk); #1;
    release_reset();
    for (int i = 0; i < T + 3; i++) begin
      @(posedge clk); #1;
      check("no_decision_after_reset", 32'(bus.odec_valid), 0);
    end

    // reset while the learn strobe is high drops it at once
    accept_header(14'h0010, 14'h0020, 2'd2, ok);
    check("req_strobe_before_reset", 32'(bus.owr_en), 1);
    rst_n = 1'b0;
    #1;
    check("req_reset_owr_en", 32'(bus.owr_en), 0);
    @(posedge clk); #1;
    release_reset();

    // back-to-back random frames against a behavioural MAC table
    for (int f = 0; f < 100; f++) begin
      sa   = ($urandom_range(0, 15) == 0) ? ONES : AW'($urandom_range(0, 11));
      da   = ($urandom_range(0, 15) == 0) ? ONES : AW'($urandom_range(0, 11));
      port = PW'($urandom_range(0, N - 1));
      if (sa != ONES) tbl[sa] = port;
      hit  = (da != ONES) && tbl.exists(da) && ($urandom_range(0, 7) != 0);
      pnum = hit ? int'(tbl[da]) : 0;
      run_frame(da, sa, port, hit, pnum, $urandom_range(0, T - 1), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
